response_misr_compactor: RTL and testbench
==========================================

// Module: response_misr_compactor
// PURPOSE
//  Downstream stage of the combinational circuit under test in the fault simulator.
//  Consumes one 16-bit output response vector per accepted beat (out0..out15 packed,
//  out0 = bit 0) and compacts it into a multiple-input signature register (MISR).
//  After a programmed number of patterns, it compares the signature against a golden
//  value and reports pass/fail for the fault-free or faulty run.
// PARAMETERS
//  WIDTH   16        response/signature width (= number of CUT primary outputs)
//  CNT_W   16        width of pattern counter and num_patterns
//  POLY    16'h1021  MISR feedback polynomial taps (x^16+x^12+x^5+1)
//  SEED    16'h0000  signature value loaded at reset and at start
// PORTS
//  clk           in   1      single clock, all state on rising edge
//  rst           in   1      synchronous, active-high reset
//  start         in   1      begin a run; sampled only in IDLE or DONE
//  num_patterns  in   CNT_W  beats to compact; sampled on accepted start
//  golden        in   WIDTH  expected signature; sampled in CHECK
//  resp_valid    in   1      response beat present on resp_data
//  resp_data     in   WIDTH  CUT response vector
//  resp_ready    out  1      compactor accepts a beat this cycle
//  busy          out  1      high in RUN and CHECK
//  done          out  1      high while in DONE (level, not pulse)
//  pass          out  1      signature == golden; valid while done=1
//  signature     out  WIDTH  current MISR contents
//  pat_count     out  CNT_W  beats accepted in the current run
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE; signature=SEED; pat_count=0; pass=0; done=0;
//   busy=0; resp_ready=0. Reset wins over every other event, including mid-run.
//  FSM: IDLE -start-> RUN (or CHECK if num_patterns==0); RUN -last beat-> CHECK;
//   CHECK -> DONE (always one cycle); DONE -start-> same as from IDLE.
//  On accepted start: signature<=SEED, pat_count<=0, pass<=0, target<=num_patterns.
//  start is ignored in RUN and CHECK.
//  resp_ready = (state==RUN), combinational from state only (no dependence on valid).
//  Beat accepted at an edge where resp_valid && resp_ready; beats without the handshake
//   do not change any state.
//  MISR update per accepted beat, same edge:
//   signature <= {signature[WIDTH-2:0],1'b0} ^ (signature[WIDTH-1] ? POLY : 0) ^ resp_data
//  pat_count increments on each accepted beat; when the beat is number target
//   (pat_count==target-1), state goes to CHECK at that edge.
//  CHECK: at the next edge pass<=(signature==golden), done<=1, state<=DONE.
//   The done/pass latency after the last accepted beat is 2 edges.
//  In DONE, signature, pass, and pat_count hold until the next start or rst.
//  num_patterns==0: no beats are accepted, and signature==SEED is compared with golden.
//  pat_count does not wrap: max run = 2^CNT_W-1 beats.
// STRUCTURE
//  Shared header fsim_defs.vh: state encodings (IDLE/RUN/CHECK/DONE, 2-bit),
//   default CUT width 16, default POLY and SEED, shared by the upstream pattern generator.
//  One sub-module misr_core (WIDTH, POLY): combinational next-signature function
//   (sig, data) -> sig_next; the top keeps the FSM, counter, register, and compare logic.
// TESTING
//  T1 reset: hold rst 2 cycles -> signature=0000, pat_count=0, resp_ready=0, done=0, pass=0.
//  T2 start, num_patterns=1, beat 0x0001, golden=0x0001 -> signature=0x0001; done
//   2 edges after the beat; pass=1.
//  T3 num_patterns=17, beats 0x0001 then 16x 0x0000, golden=0x1020 -> signature=0x1021,
//   pat_count=17, pass=0.
//  T4 resp_valid toggling 1/0 with 0x0001 on every cycle and num_patterns=2 -> only 2
//   handshakes counted; signature=0x0003; resp_ready low after the 2nd beat.
//  T5 num_patterns=0, golden=0x0000 -> no handshake; done 2 edges after start; pass=1;
//   a start pulse during RUN in any other test has no effect.
//  T6 rst during RUN after 3 beats -> next cycle IDLE, signature=0000, pat_count=0;
//   rerun of T2 passes.

Source files
------------

// File: rtl/response_misr_compactor_pkg.sv
// Shared definitions for the response compactor and the upstream pattern generator:
// FSM state encodings, default CUT output width, default MISR polynomial and seed.
package response_misr_compactor_pkg;

    localparam int          CUT_W    = 16;
    localparam logic [15:0] DEF_POLY = 16'h1021;
    localparam logic [15:0] DEF_SEED = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/response_misr_compactor_misr_core.sv
// misr_core: combinational next-state function of the MISR.
// Ports: sig (current signature), data (response beat), sig_next (updated signature).
import response_misr_compactor_pkg::*;

module misr_core #(
    parameter int               WIDTH = CUT_W,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEF_POLY)
) (
    input  logic [WIDTH-1:0] sig,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] sig_next
);

    logic [WIDTH-1:0] fb;

    // Feedback taps are applied only when the bit shifted out is set.
    assign fb       = sig[WIDTH-1] ? POLY : '0;
    assign sig_next = {sig[WIDTH-2:0], 1'b0} ^ fb ^ data;

endmodule

// File: rtl/response_misr_compactor.sv
// response_misr_compactor: compacts CUT response beats into a MISR and compares the
// final signature against a golden value after num_patterns accepted beats.
// Ports: clk, rst (sync, active high); start, num_patterns, golden (run control);
//   resp_valid/resp_data/resp_ready (response handshake); busy, done, pass,
//   signature, pat_count (status).
import response_misr_compactor_pkg::*;

module response_misr_compactor #(
    parameter int               WIDTH = CUT_W,
    parameter int               CNT_W = 16,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEF_POLY),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_patterns,
    input  logic [WIDTH-1:0] golden,
    input  logic             resp_valid,
    input  logic [WIDTH-1:0] resp_data,
    output logic             resp_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature,
    output logic [CNT_W-1:0] pat_count
);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] target;
    logic [WIDTH-1:0] sig_next;
    logic             start_ok;
    logic             beat;
    logic             last_beat;

    misr_core #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_misr (
        .sig      (signature),
        .data     (resp_data),
        .sig_next (sig_next)
    );

    assign start_ok   = start && (state == ST_IDLE || state == ST_DONE);
    assign resp_ready = (state == ST_RUN);
    assign beat       = resp_valid && resp_ready;
    // Beat number `target` is the one seen while pat_count == target-1.
    assign last_beat  = beat && (pat_count == target - CNT_W'(1));
    assign busy       = (state == ST_RUN) || (state == ST_CHECK);
    assign done       = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    state_nx = (num_patterns == '0) ? ST_CHECK : ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_beat) begin
                    state_nx = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_nx = ST_DONE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            signature <= SEED;
            pat_count <= '0;
            pass      <= 1'b0;
            target    <= '0;
        end else if (start_ok) begin
            signature <= SEED;
            pat_count <= '0;
            pass      <= 1'b0;
            target    <= num_patterns;
        end else if (beat) begin
            signature <= sig_next;
            pat_count <= pat_count + CNT_W'(1);
        end else if (state == ST_CHECK) begin
            pass <= (signature == golden);
        end
    end

endmodule

// File: tb/tb_response_misr_compactor.sv
// Directed bench for response_misr_compactor with hand-computed signatures.
// Drives inputs and samples outputs 1 time unit after each rising edge.
module tb_response_misr_compactor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] num_patterns;
    logic [15:0] golden;
    logic        resp_valid;
    logic [15:0] resp_data;
    logic        resp_ready;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] signature;
    logic [15:0] pat_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    response_misr_compactor dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_patterns (num_patterns),
        .golden       (golden),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .resp_ready   (resp_ready),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .signature    (signature),
        .pat_count    (pat_count)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] n, input logic [15:0] g);
        start        = 1'b1;
        num_patterns = n;
        golden       = g;
        tick();
        start = 1'b0;
    endtask

    // One beat, presented for exactly one edge; ready must already be up.
    task automatic send_beat(input string tag, input logic [15:0] d);
        resp_valid = 1'b1;
        resp_data  = d;
        check(tag, resp_ready, 1);
        tick();
        resp_valid = 1'b0;
        resp_data  = 16'h0000;
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        num_patterns = '0;
        golden       = '0;
        resp_valid   = 1'b0;
        resp_data    = '0;

        // T1 reset
        tick();
        tick();
        check("t1_sig", signature, 16'h0000);
        check("t1_cnt", pat_count, 0);
        check("t1_rdy", resp_ready, 0);
        check("t1_done", done, 0);
        check("t1_pass", pass, 0);
        check("t1_busy", busy, 0);
        rst = 1'b0;
        tick();
        check("t1_idle_rdy", resp_ready, 0);

        // T2 single beat
        do_start(16'd1, 16'h0001);
        check("t2_busy", busy, 1);
        send_beat("t2_rdy", 16'h0001);
        check("t2_done_e1", done, 0);
        check("t2_sig", signature, 16'h0001);
        tick();
        check("t2_done_e2", done, 1);
        check("t2_pass", pass, 1);
        check("t2_busy_off", busy, 0);

        // Beat offered in DONE must not change anything
        resp_valid = 1'b1;
        resp_data  = 16'hffff;
        tick();
        resp_valid = 1'b0;
        check("t2_hold_sig", signature, 16'h0001);
        check("t2_hold_cnt", pat_count, 1);
        check("t2_hold_done", done, 1);

        // T3 17 beats, wraps feedback once; also start during RUN ignored
        do_start(16'd17, 16'h1020);
        send_beat("t3_rdy0", 16'h0001);
        for (int i = 0; i < 16; i++) begin
            if (i == 5) begin
                start        = 1'b1;
                num_patterns = 16'd3;
            end
            send_beat("t3_rdy", 16'h0000);
            start = 1'b0;
            if (i == 14) check("t3_sig15", signature, 16'h8000);
        end
        check("t3_sig", signature, 16'h1021);
        check("t3_cnt", pat_count, 17);
        check("t3_rdy_off", resp_ready, 0);
        tick();
        check("t3_done", done, 1);
        check("t3_pass", pass, 0);

        // T4 toggling valid, two beats expected
        do_start(16'd2, 16'h0003);
        begin
            int cyc;
            cyc = 0;
            while (!done && cyc < 12) begin
                resp_valid = (cyc % 2 == 0);
                resp_data  = 16'h0001;
                tick();
                cyc++;
                if (cyc == 3) begin
                    check("t4_cnt", pat_count, 2);
                    check("t4_sig", signature, 16'h0003);
                    check("t4_rdy_off", resp_ready, 0);
                end
            end
            resp_valid = 1'b0;
            check("t4_done_timeout", done, 1);
            check("t4_cycles", cyc, 4);
        end
        check("t4_final_cnt", pat_count, 2);
        check("t4_pass", pass, 1);

        // T5 zero patterns
        do_start(16'd0, 16'h0000);
        check("t5_rdy", resp_ready, 0);
        check("t5_done_e1", done, 0);
        check("t5_sig", signature, 16'h0000);
        tick();
        check("t5_done_e2", done, 1);
        check("t5_pass", pass, 1);
        check("t5_cnt", pat_count, 0);

        // T6 reset mid-run, then rerun T2
        do_start(16'd10, 16'h0000);
        send_beat("t6_rdy0", 16'h0001);
        send_beat("t6_rdy1", 16'h0001);
        send_beat("t6_rdy2", 16'h0001);
        check("t6_sig3", signature, 16'h0007);
        check("t6_cnt3", pat_count, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_sig", signature, 16'h0000);
        check("t6_cnt", pat_count, 0);
        check("t6_rdy", resp_ready, 0);
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        do_start(16'd1, 16'h0001);
        send_beat("t6_rdy_rerun", 16'h0001);
        tick();
        check("t6_rerun_done", done, 1);
        check("t6_rerun_pass", pass, 1);
        check("t6_rerun_sig", signature, 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
